fir_coeff_loader: RTL
=====================

Name: fir_coeff_loader

Overview:
- Upstream configuration stage for the polyphase FIR decimator.
- Receives a byte stream of filter coefficients over a valid/ready handshake and assembles them into COEFF_SIZE words.
- Drives the decimator's coefficient write port (c_we, c_in, c_addr) and holds the filter frozen for the whole session.
- Verifies a trailing checksum byte and reports done or error.

Parameters:
- ORD, 255, filter order; the filter has ORD+1 taps.
- M, 8, decimation factor (number of polyphase branches).
- COEFF_SIZE, 16, coefficient width in bits; must be a multiple of 8.
- NCOEF, derived localparam = (((ORD+1)/M+1)/2)*M. This is the number of unique symmetric coefficients; 128 at the defaults.
- BPC, derived localparam = COEFF_SIZE/8, the number of bytes per coefficient.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle request to begin a load session.
- s_valid  in  1  byte stream valid.
- s_ready  out  1  byte stream ready.
- s_data  in  8  byte stream data; coefficients arrive little-endian, in address order.
- c_we  out  1  coefficient write enable and filter freeze, to the decimator.
- c_in  out  COEFF_SIZE  assembled coefficient.
- c_addr  out  $clog2(ORD+1)  coefficient address.
- busy  out  1  a session is in progress.
- done  out  1  one-cycle pulse when a session ends with a good checksum.
- err  out  1  sticky checksum-mismatch flag; cleared by the next load_start.

Behaviour:
- Reset (asynchronous, nrst low): state IDLE. All outputs are 0: s_ready, c_we, c_in, c_addr, busy, done, err. All counters and the checksum accumulator are 0.
- A transfer occurs on any cycle with s_valid && s_ready.
- IDLE:
  - s_ready=0, c_we=0.
  - load_start=1 moves to RECV on the next edge, and at that edge sets c_we=1, busy=1, clears err, and zeroes byte_cnt, word_cnt and csum.
- RECV:
  - s_ready=1.
  - Each transfer places s_data into byte lane byte_cnt of a shift buffer, adds it to csum (mod 256), and increments byte_cnt.
  - On the transfer with byte_cnt==BPC-1, the following all happen at the next edge as one atomic register update:
    - c_in <= the assembled word.
    - c_addr <= word_cnt.
    - word_cnt is incremented and byte_cnt returns to 0.
  - The write latency is therefore 1 cycle from the last byte of a word to the new c_in/c_addr.
  - When the completed word has index NCOEF-1, go to CSUM.
  - c_in and c_addr never change other than through that atomic update. This guarantees the decimator, which writes on every cycle while c_we is high, only ever sees matching address/data pairs.
  - In the cycles between load_start and the first completed word, the outputs are c_addr=0 and c_in=0. Address 0 is overwritten later in the session, so this is harmless.
- CSUM:
  - s_ready=1.
  - A transfer computes csum + s_data (mod 256) and moves to IDLE at the next edge. At that edge c_we=0, busy=0 and s_ready=0.
  - If the result is 0: done=1 for exactly one cycle.
  - Otherwise: err=1, held until the next load_start.
- The decimator resumes its counters in the cycle after c_we falls.
- Boundary conditions:
  - load_start while busy: ignored.
  - load_start and s_valid in the same cycle in IDLE: the byte is not accepted, because s_ready is 0.
  - s_valid held low mid-word or mid-session: wait indefinitely. There is no timeout; c_we stays high.
  - s_valid high in IDLE: no transfer; the byte is not consumed.
  - c_addr only takes values 0..NCOEF-1 and never wraps.
  - nrst asserted mid-session: immediate abort; c_we drops asynchronously. Coefficients already written stay in the decimator; software must reload.
- Width rules:
  - csum is 8 bits with wraparound.
  - word_cnt is $clog2(NCOEF+1) bits.
  - byte_cnt is $clog2(BPC+1) bits; for BPC==1, byte_cnt is held at 0.

Decomposition:
- Shared package holds: the FSM state enum (IDLE, RECV, CSUM); the derived localparams NCOEF and BPC; and the helper function for the symmetric coefficient count, reused by the decimator's address decoder.
- One natural sub-module, coeff_byte_assembler. It handles byte lane insertion, byte_cnt, and the word-complete strobe.
- The FSM, address and checksum logic stay in the top module.

Test Plan:
- Basic load at defaults: load_start, then 256 bytes for the coefficients 0x0001..0x0080 plus the correct checksum byte, with s_valid held high.
  - Required: c_addr steps 0..127 with c_in = c_addr+1, each pair stable until the next word.
  - Required: done pulses once, 1 cycle after the checksum byte; c_we falls in the same cycle; err=0.
- Bad checksum: same stream with the checksum byte +1.
  - Required: err=1 and stays high, done never pulses, c_we=0. The next load_start clears err.
- Backpressure gaps: random s_valid gaps of 0–5 cycles, including mid-word.
  - Required: identical c_in/c_addr sequence to the basic load; c_in never changes while c_addr is constant.
- Reset mid-session: assert nrst after 37 words.
  - Required: c_we=0 and busy=0 immediately.
  - Required: a subsequent full load completes with done=1 and c_addr ending at 127.
- load_start while busy: pulse load_start at word 10.
  - Required: no restart; word_cnt continues and the session ends normally with done.
- Parameter sweep with ORD=63, M=4, COEFF_SIZE=24.
  - Required: NCOEF=32 and BPC=3; the last c_addr is 31; little-endian assembly is verified with coefficient 0xA1B2C3 sent as bytes C3 B2 A1.

Source files
------------

// File: rtl/fir_coeff_loader_pkg.sv
// fir_coeff_loader_pkg: shared state encoding, default sizing and symmetric coefficient count
package fir_coeff_loader_pkg;

   typedef enum logic [1:0] {IDLE, RECV, CSUM} state_t;

   localparam int ORD_DEF        = 255;
   localparam int M_DEF          = 8;
   localparam int COEFF_SIZE_DEF = 16;

   // unique coefficients of a symmetric polyphase filter, rounded up to whole branches
   function automatic int sym_ncoef(input int ord, input int m);
      return (((ord + 1) / m + 1) / 2) * m;
   endfunction

   localparam int NCOEF_DEF = sym_ncoef(ORD_DEF, M_DEF);
   localparam int BPC_DEF   = COEFF_SIZE_DEF / 8;

endpackage

// File: rtl/fir_coeff_loader_coeff_byte_assembler.sv
// coeff_byte_assembler: places little-endian bytes into coefficient lanes and flags each completed word
module coeff_byte_assembler
   import fir_coeff_loader_pkg::*;
#(
   parameter int COEFF_SIZE = COEFF_SIZE_DEF,
   parameter int BPC        = COEFF_SIZE / 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  clear,
   input  logic                  xfer,
   input  logic [7:0]            s_data,
   output logic [COEFF_SIZE-1:0] word,
   output logic                  word_done
);

   localparam int BW = $clog2(BPC + 1);
   localparam logic [BW-1:0] LAST = BW'(BPC - 1);

   logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
   logic [COEFF_SIZE-1:0] lane_q, lane_d;

   // word is the buffer including the byte arriving now, so the top can register it on the same edge
   always_comb begin
      lane_d = lane_q;
      if (xfer) lane_d[8*int'(byte_cnt_q) +: 8] = s_data;
      word_done  = xfer && byte_cnt_q == LAST;
      byte_cnt_d = clear || word_done ? '0 : xfer ? byte_cnt_q + 1'b1 : byte_cnt_q;
      word       = lane_d;
   end

   // lane buffer and byte counter registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         byte_cnt_q <= '0;
         lane_q     <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         lane_q     <= lane_d;
      end
   end

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: byte-stream coefficient loader with checksum, driving the decimator write port
module fir_coeff_loader
   import fir_coeff_loader_pkg::*;
#(
   parameter int ORD        = ORD_DEF,
   parameter int M          = M_DEF,
   parameter int COEFF_SIZE = COEFF_SIZE_DEF
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       load_start,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [7:0]                 s_data,
   output logic                       c_we,
   output logic [COEFF_SIZE-1:0]      c_in,
   output logic [$clog2(ORD+1)-1:0]   c_addr,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int NCOEF = sym_ncoef(ORD, M);
   localparam int BPC   = COEFF_SIZE / 8;
   localparam int AW    = $clog2(ORD + 1);
   localparam int WW    = $clog2(NCOEF + 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(NCOEF - 1);

   state_t                state_q, state_d;
   logic [7:0]            csum_q, csum_d, sum;
   logic [WW-1:0]         word_cnt_q, word_cnt_d;
   logic [COEFF_SIZE-1:0] c_in_q, c_in_d, word;
   logic [AW-1:0]         c_addr_q, c_addr_d;
   logic                  done_q, done_d, err_q, err_d;
   logic                  xfer, clear, word_done;

   // freeze, ready and busy all follow the session; reset drops them asynchronously
   assign s_ready = state_q != IDLE;
   assign c_we    = s_ready;
   assign busy    = s_ready;
   assign xfer    = s_valid && s_ready;
   assign clear   = state_q == IDLE && load_start;
   assign c_in    = c_in_q;
   assign c_addr  = c_addr_q;
   assign done    = done_q;
   assign err     = err_q;

   coeff_byte_assembler #(
      .COEFF_SIZE (COEFF_SIZE),
      .BPC        (BPC)
   ) u_asm (
      .clk       (clk),
      .nrst      (nrst),
      .clear     (clear),
      .xfer      (xfer && state_q == RECV),
      .s_data    (s_data),
      .word      (word),
      .word_done (word_done)
   );

   // session FSM; address and data change together only on a completed word
   always_comb begin
      state_d    = state_q;
      csum_d     = csum_q;
      word_cnt_d = word_cnt_q;
      c_in_d     = c_in_q;
      c_addr_d   = c_addr_q;
      done_d     = 1'b0;
      err_d      = err_q;
      sum        = csum_q + s_data;
      if (clear) begin
         state_d    = RECV;
         csum_d     = '0;
         word_cnt_d = '0;
         c_in_d     = '0;
         c_addr_d   = '0;
         err_d      = 1'b0;
      end
      if (xfer) csum_d = sum;
      if (word_done) begin
         c_in_d     = word;
         c_addr_d   = AW'(word_cnt_q);
         word_cnt_d = word_cnt_q + 1'b1;
         if (word_cnt_q == LAST_WORD) state_d = CSUM;
      end
      if (xfer && state_q == CSUM) begin
         state_d = IDLE;
         done_d  = sum == 8'd0;
         err_d   = sum != 8'd0;
      end
   end

   // session registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         csum_q     <= '0;
         word_cnt_q <= '0;
         c_in_q     <= '0;
         c_addr_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         csum_q     <= csum_d;
         word_cnt_q <= word_cnt_d;
         c_in_q     <= c_in_d;
         c_addr_q   <= c_addr_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

endmodule
